// File: rtl/mem_channel_arbiter.sv
// Round-robin arbiter sharing NUM_CHANNELS memory channels among NUM_CONSUMERS requesters.
// Define MEM_ARB_PERF_EN to add the saturating busy_cycles counter port.
module mem_channel_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]                              busy_cycles
`endif
);

    localparam int CW  = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam int CWP = CW + 1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ_WAIT  = 2'd1,
        ST_WRITE_WAIT = 2'd2,
        ST_RELAY      = 2'd3
    } ch_state_e;

    ch_state_e                               state_q [NUM_CHANNELS];
    ch_state_e                               state_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][CW-1:0]         owner_q, owner_d;
    logic [NUM_CHANNELS-1:0]                 is_write_q, is_write_d;
    logic [NUM_CONSUMERS-1:0]                owned_q, owned_d;
    logic [CW-1:0]                           rr_ptr_q, rr_ptr_d;
    logic [NUM_CHANNELS-1:0]                 mem_read_valid_q, mem_read_valid_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address_q, mem_read_address_d;
    logic [NUM_CHANNELS-1:0]                 mem_write_valid_q, mem_write_valid_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address_q, mem_write_address_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data_q, mem_write_data_d;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready_q, consumer_read_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data_q, consumer_read_data_d;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready_q, consumer_write_ready_d;

    logic [NUM_CONSUMERS-1:0] taken_s;
    logic                     found_s;
    logic [CW-1:0]            idx_s;
    logic [CW-1:0]            own_s;

    function automatic logic [CW-1:0] wrap_idx(input logic [CWP-1:0] v);
        logic [CWP-1:0] r;
        if (v >= CWP'(NUM_CONSUMERS)) begin
            r = v - CWP'(NUM_CONSUMERS);
        end else begin
            r = v;
        end
        return r[CW-1:0];
    endfunction

    // Per-channel next state, grants in channel order, and relay/release handling.
    always_comb begin
        state_d                = state_q;
        owner_d                = owner_q;
        is_write_d             = is_write_q;
        owned_d                = owned_q;
        rr_ptr_d               = rr_ptr_q;
        mem_read_valid_d       = mem_read_valid_q;
        mem_read_address_d     = mem_read_address_q;
        mem_write_valid_d      = mem_write_valid_q;
        mem_write_address_d    = mem_write_address_q;
        mem_write_data_d       = mem_write_data_q;
        consumer_read_ready_d  = consumer_read_ready_q;
        consumer_read_data_d   = consumer_read_data_q;
        consumer_write_ready_d = consumer_write_ready_q;
        taken_s                = owned_q;
        found_s                = 1'b0;
        idx_s                  = '0;
        own_s                  = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            own_s = owner_q[ch];
            case (state_q[ch])
                ST_IDLE: begin
                    found_s = 1'b0;
                    for (int i = 0; i < NUM_CONSUMERS; i++) begin
                        idx_s = wrap_idx({1'b0, rr_ptr_q} + CWP'(i));
                        if (!found_s && !taken_s[idx_s] &&
                            (consumer_read_valid[idx_s] || consumer_write_valid[idx_s])) begin
                            found_s        = 1'b1;
                            taken_s[idx_s] = 1'b1;
                            owned_d[idx_s] = 1'b1;
                            owner_d[ch]    = idx_s;
                            rr_ptr_d       = wrap_idx({1'b0, idx_s} + CWP'(1));
                            // Read has priority when a consumer raises both.
                            if (consumer_read_valid[idx_s]) begin
                                state_d[ch]            = ST_READ_WAIT;
                                is_write_d[ch]         = 1'b0;
                                mem_read_valid_d[ch]   = 1'b1;
                                mem_read_address_d[ch] = consumer_read_address[idx_s];
                            end else begin
                                state_d[ch]             = ST_WRITE_WAIT;
                                is_write_d[ch]          = 1'b1;
                                mem_write_valid_d[ch]   = 1'b1;
                                mem_write_address_d[ch] = consumer_write_address[idx_s];
                                mem_write_data_d[ch]    = consumer_write_data[idx_s];
                            end
                        end else begin
                            found_s = found_s;
                        end
                    end
                end
                ST_READ_WAIT: begin
                    if (mem_read_ready[ch]) begin
                        mem_read_valid_d[ch]         = 1'b0;
                        consumer_read_ready_d[own_s] = 1'b1;
                        consumer_read_data_d[own_s]  = mem_read_data[ch];
                        state_d[ch]                  = ST_RELAY;
                    end else begin
                        state_d[ch] = ST_READ_WAIT;
                    end
                end
                ST_WRITE_WAIT: begin
                    if (mem_write_ready[ch]) begin
                        mem_write_valid_d[ch]         = 1'b0;
                        consumer_write_ready_d[own_s] = 1'b1;
                        state_d[ch]                   = ST_RELAY;
                    end else begin
                        state_d[ch] = ST_WRITE_WAIT;
                    end
                end
                ST_RELAY: begin
                    if (is_write_q[ch] && !consumer_write_valid[own_s]) begin
                        consumer_write_ready_d[own_s] = 1'b0;
                        owned_d[own_s]                = 1'b0;
                        state_d[ch]                   = ST_IDLE;
                    end else if (!is_write_q[ch] && !consumer_read_valid[own_s]) begin
                        consumer_read_ready_d[own_s] = 1'b0;
                        owned_d[own_s]               = 1'b0;
                        state_d[ch]                  = ST_IDLE;
                    end else begin
                        state_d[ch] = ST_RELAY;
                    end
                end
                default: begin
                    state_d[ch] = ST_IDLE;
                end
            endcase
        end
    end

    // State, ownership and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= ST_IDLE;
            end
            owner_q                <= '0;
            is_write_q             <= '0;
            owned_q                <= '0;
            rr_ptr_q               <= '0;
            mem_read_valid_q       <= '0;
            mem_read_address_q     <= '0;
            mem_write_valid_q      <= '0;
            mem_write_address_q    <= '0;
            mem_write_data_q       <= '0;
            consumer_read_ready_q  <= '0;
            consumer_read_data_q   <= '0;
            consumer_write_ready_q <= '0;
        end else begin
            state_q                <= state_d;
            owner_q                <= owner_d;
            is_write_q             <= is_write_d;
            owned_q                <= owned_d;
            rr_ptr_q               <= rr_ptr_d;
            mem_read_valid_q       <= mem_read_valid_d;
            mem_read_address_q     <= mem_read_address_d;
            mem_write_valid_q      <= mem_write_valid_d;
            mem_write_address_q    <= mem_write_address_d;
            mem_write_data_q       <= mem_write_data_d;
            consumer_read_ready_q  <= consumer_read_ready_d;
            consumer_read_data_q   <= consumer_read_data_d;
            consumer_write_ready_q <= consumer_write_ready_d;
        end
    end

    assign mem_read_valid       = mem_read_valid_q;
    assign mem_read_address     = mem_read_address_q;
    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;
    assign consumer_read_ready  = consumer_read_ready_q;
    assign consumer_read_data   = consumer_read_data_q;
    assign consumer_write_ready = consumer_write_ready_q;

`ifdef MEM_ARB_PERF_EN
    logic [15:0] busy_cycles_q, busy_cycles_d;
    logic        any_busy_s;

    // Saturating count of cycles with at least one channel active.
    always_comb begin
        any_busy_s = 1'b0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            any_busy_s = any_busy_s | (state_q[ch] != ST_IDLE);
        end
        if (any_busy_s && (busy_cycles_q != 16'hFFFF)) begin
            busy_cycles_d = busy_cycles_q + 16'd1;
        end else begin
            busy_cycles_d = busy_cycles_q;
        end
    end

    // Busy counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cycles_q <= 16'd0;
        end else begin
            busy_cycles_q <= busy_cycles_d;
        end
    end

    assign busy_cycles = busy_cycles_q;
`endif

endmodule
